// File: rtl/ama_riscv_mmio_uart_pkg.sv
// Shared types and sizes for the MMIO UART peripheral.
package ama_riscv_mmio_uart_pkg;

  localparam int UART_DATA_W        = 8;
  localparam int UART_RX_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

endpackage

// File: rtl/ama_riscv_uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, RX FSM and bit counter.
// rx_accept pulses for one cycle when a byte with a valid stop bit is sampled;
// rx_data holds that byte in the same cycle.
module ama_riscv_uart_rx
  import ama_riscv_mmio_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   serial_in,
  output logic [UART_DATA_W-1:0] rx_data,
  output logic                   rx_accept
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  logic                   sync_q1, sync_q2;
  uart_state_t            state, state_d;
  logic [CNT_W-1:0]       cnt, cnt_d;
  logic [2:0]             bit_idx, bit_idx_d;
  logic [UART_DATA_W-1:0] shift, shift_d;

  // Synchronizer resets to idle-high so leaving reset never looks like a start bit
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q1 <= 1'b1;
      sync_q2 <= 1'b1;
    end else begin
      sync_q1 <= serial_in;
      sync_q2 <= sync_q1;
    end
  end

  // FSM and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      bit_idx <= bit_idx_d;
      shift   <= shift_d;
    end
  end

  // Next state: start bit confirmed at mid-bit, then one sample per bit period
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    bit_idx_d = bit_idx;
    shift_d   = shift;
    rx_accept = 1'b0;
    case (state)
      IDLE: begin
        cnt_d = '0;
        if (!sync_q2) state_d = START;
      end
      START: begin
        if (cnt == HALF_LAST) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = sync_q2 ? IDLE : DATA;  // high at mid-bit: glitch
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {sync_q2, shift[UART_DATA_W-1:1]};  // LSB arrives first
          if (bit_idx == 3'(UART_DATA_W - 1)) state_d = STOP;
          else bit_idx_d = bit_idx + 3'd1;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_d     = '0;
          state_d   = IDLE;
          rx_accept = sync_q2;  // low stop bit: framing error, byte dropped
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rx_data = shift;

endmodule

// File: rtl/ama_riscv_mmio_uart.sv
// MMIO UART peripheral: 8N1 TX, RX (sub-module), RX holding register or FIFO,
// plus cycle and retired-instruction counters.
// Build option: MMIO_UART_RX_FIFO_EN replaces the RX holding register with a
// UART_RX_FIFO_DEPTH-entry FIFO.
module ama_riscv_mmio_uart
  import ama_riscv_mmio_uart_pkg::*;
#(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD_RATE = 115_200
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   serial_in,
  output logic                   serial_out,
  input  logic                   store_to_uart,
  input  logic [UART_DATA_W-1:0] mmio_uart_data_in,
  input  logic                   load_from_uart,
  input  logic                   mmio_reset_cnt,
  input  logic                   inst_wb_nop_or_clear,
  output logic [UART_DATA_W-1:0] mmio_uart_data_out,
  output logic                   mmio_data_out_valid,
  output logic                   mmio_data_in_ready,
  output logic [31:0]            mmio_cycle_cnt,
  output logic [31:0]            mmio_instr_cnt
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  // Counters: reset level wins over increment; both wrap naturally
  always_ff @(posedge clk) begin
    if (rst || mmio_reset_cnt) begin
      mmio_cycle_cnt <= '0;
      mmio_instr_cnt <= '0;
    end else begin
      mmio_cycle_cnt <= mmio_cycle_cnt + 32'd1;
      if (!inst_wb_nop_or_clear) mmio_instr_cnt <= mmio_instr_cnt + 32'd1;
    end
  end

  // ---------------- TX ----------------
  logic                   tx_start_q;
  uart_state_t            tx_state, tx_state_d;
  logic [CNT_W-1:0]       tx_cnt, tx_cnt_d;
  logic [2:0]             tx_bit, tx_bit_d;
  logic [UART_DATA_W-1:0] tx_shift, tx_shift_d;
  logic                   tx_out_d;

  // Store strobe is registered so the byte (valid one cycle later) lines up with it
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_start_q <= 1'b0;
      tx_state   <= IDLE;
      tx_cnt     <= '0;
      tx_bit     <= '0;
      tx_shift   <= '0;
      serial_out <= 1'b1;
    end else begin
      tx_start_q <= store_to_uart;
      tx_state   <= tx_state_d;
      tx_cnt     <= tx_cnt_d;
      tx_bit     <= tx_bit_d;
      tx_shift   <= tx_shift_d;
      serial_out <= tx_out_d;
    end
  end

  // TX next state; a start request outside IDLE is ignored (byte dropped)
  always_comb begin
    tx_state_d = tx_state;
    tx_cnt_d   = tx_cnt;
    tx_bit_d   = tx_bit;
    tx_shift_d = tx_shift;
    tx_out_d   = serial_out;
    case (tx_state)
      IDLE: begin
        if (tx_start_q) begin
          tx_state_d = START;
          tx_shift_d = mmio_uart_data_in;
          tx_cnt_d   = '0;
          tx_out_d   = 1'b0;
        end
      end
      START: begin
        if (tx_cnt == BIT_LAST) begin
          tx_state_d = DATA;
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_out_d   = tx_shift[0];
        end else begin
          tx_cnt_d = tx_cnt + CNT_W'(1);
        end
      end
      DATA: begin
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_d = '0;
          if (tx_bit == 3'(UART_DATA_W - 1)) begin
            tx_state_d = STOP;
            tx_out_d   = 1'b1;
          end else begin
            tx_bit_d   = tx_bit + 3'd1;
            tx_shift_d = {1'b0, tx_shift[UART_DATA_W-1:1]};
            tx_out_d   = tx_shift[1];
          end
        end else begin
          tx_cnt_d = tx_cnt + CNT_W'(1);
        end
      end
      STOP: begin
        if (tx_cnt == BIT_LAST) begin
          tx_state_d = IDLE;
          tx_cnt_d   = '0;
        end else begin
          tx_cnt_d = tx_cnt + CNT_W'(1);
        end
      end
      default: tx_state_d = IDLE;
    endcase
  end

  assign mmio_data_in_ready = (tx_state == IDLE) && !tx_start_q;

  // ---------------- RX ----------------
  logic [UART_DATA_W-1:0] rx_data;
  logic                   rx_accept;

  ama_riscv_uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk       (clk),
    .rst       (rst),
    .serial_in (serial_in),
    .rx_data   (rx_data),
    .rx_accept (rx_accept)
  );

`ifdef MMIO_UART_RX_FIFO_EN
  localparam int PTR_W = $clog2(UART_RX_FIFO_DEPTH);
  localparam logic [PTR_W:0] FIFO_FULL = (PTR_W+1)'(UART_RX_FIFO_DEPTH);

  logic [UART_RX_FIFO_DEPTH-1:0][UART_DATA_W-1:0] fifo_mem;
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [PTR_W:0]   fifo_cnt;
  logic             push, pop;

  // Pop is resolved first so a full FIFO can still take a byte on a pop cycle
  assign pop  = load_from_uart && (fifo_cnt != '0);
  assign push = rx_accept && ((fifo_cnt != FIFO_FULL) || pop);

  // RX FIFO: pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_mem <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= rx_data;
        wr_ptr           <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      fifo_cnt <= fifo_cnt + (PTR_W+1)'(1);
      else if (pop && !push) fifo_cnt <= fifo_cnt - (PTR_W+1)'(1);
    end
  end

  assign mmio_uart_data_out  = fifo_mem[rd_ptr];
  assign mmio_data_out_valid = (fifo_cnt != '0);
`else
  // Single holding register: new byte overwrites, and wins over a same-cycle load
  always_ff @(posedge clk) begin
    if (rst) begin
      mmio_uart_data_out  <= '0;
      mmio_data_out_valid <= 1'b0;
    end else if (rx_accept) begin
      mmio_uart_data_out  <= rx_data;
      mmio_data_out_valid <= 1'b1;
    end else if (load_from_uart) begin
      mmio_data_out_valid <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_ama_riscv_mmio_uart.sv
// Self-checking bench for ama_riscv_mmio_uart (CLKS_PER_BIT = 10).
// Build with MMIO_UART_RX_FIFO_EN defined to exercise the RX FIFO variant.
module tb_ama_riscv_mmio_uart;

  localparam int CPB = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        serial_in = 1'b1;
  logic        serial_out;
  logic        store_to_uart = 1'b0;
  logic [7:0]  mmio_uart_data_in = 8'h00;
  logic        load_from_uart = 1'b0;
  logic        mmio_reset_cnt = 1'b0;
  logic        inst_wb_nop_or_clear = 1'b0;
  logic [7:0]  mmio_uart_data_out;
  logic        mmio_data_out_valid;
  logic        mmio_data_in_ready;
  logic [31:0] mmio_cycle_cnt;
  logic [31:0] mmio_instr_cnt;

  int errors = 0;
  int checks = 0;

  logic       tx_q[$];  // expected serial_out per cycle
  logic [7:0] rx_q[$];  // expected bytes the core will read

  always #5 clk = ~clk;

  ama_riscv_mmio_uart #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .serial_in            (serial_in),
    .serial_out           (serial_out),
    .store_to_uart        (store_to_uart),
    .mmio_uart_data_in    (mmio_uart_data_in),
    .load_from_uart       (load_from_uart),
    .mmio_reset_cnt       (mmio_reset_cnt),
    .inst_wb_nop_or_clear (inst_wb_nop_or_clear),
    .mmio_uart_data_out   (mmio_uart_data_out),
    .mmio_data_out_valid  (mmio_data_out_valid),
    .mmio_data_in_ready   (mmio_data_in_ready),
    .mmio_cycle_cnt       (mmio_cycle_cnt),
    .mmio_instr_cnt       (mmio_instr_cnt)
  );

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Reference model of what the core can read back after a good frame
  function automatic void model_push(input logic [7:0] b);
`ifdef MMIO_UART_RX_FIFO_EN
    if (rx_q.size() < 4) rx_q.push_back(b);
`else
    if (rx_q.size() == 1) rx_q[0] = b;
    else rx_q.push_back(b);
`endif
  endfunction

  // Drive one 8N1 frame starting at the current negedge; line left idle-high
  task automatic send_frame(input logic [7:0] b, input logic stop_b);
    serial_in = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      serial_in = b[i];
      repeat (CPB) @(negedge clk);
    end
    serial_in = stop_b;
    repeat (CPB) @(negedge clk);
    serial_in = 1'b1;
    if (stop_b) model_push(b);
  endtask

  // Read every expected byte via load pulses, then confirm nothing is left
  task automatic drain_rx(input string name);
    int n;
    n = rx_q.size();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checks++;
      if (mmio_data_out_valid !== 1'b1 || mmio_uart_data_out !== rx_q[0]) begin
        errors++;
        $display("FAIL %s byte%0d: valid=%b data=%h expected valid=1 data=%h",
                 name, i, mmio_data_out_valid, mmio_uart_data_out, rx_q[0]);
      end
      void'(rx_q.pop_front());
      load_from_uart = 1'b1;
      @(negedge clk);
      load_from_uart = 1'b0;
    end
    @(negedge clk);
    checks++;
    if (mmio_data_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s empty: valid=%b expected 0", name, mmio_data_out_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (serial_out !== 1'b1 || mmio_data_in_ready !== 1'b1 || mmio_data_out_valid !== 1'b0 ||
        mmio_uart_data_out !== 8'h00 || mmio_cycle_cnt !== 32'd0 || mmio_instr_cnt !== 32'd0) begin
      errors++;
      $display("FAIL reset_values: so=%b rdy=%b vld=%b data=%h cyc=%0d ins=%0d expected 1 1 0 00 0 0",
               serial_out, mmio_data_in_ready, mmio_data_out_valid, mmio_uart_data_out,
               mmio_cycle_cnt, mmio_instr_cnt);
    end
    rst = 1'b0;
    repeat (100) @(negedge clk);
    checks++;
    if (mmio_cycle_cnt !== 32'd100 || mmio_instr_cnt !== 32'd100) begin
      errors++;
      $display("FAIL idle_counters: cyc=%0d ins=%0d expected 100 100", mmio_cycle_cnt, mmio_instr_cnt);
    end
    checks++;
    if (serial_out !== 1'b1 || mmio_data_in_ready !== 1'b1 || mmio_data_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_status: so=%b rdy=%b vld=%b expected 1 1 0",
               serial_out, mmio_data_in_ready, mmio_data_out_valid);
    end
  endtask

  task automatic test_tx();
    logic [7:0] b;
    logic       quiet;
    b = 8'hA5;
    // cycle N: strobe with a junk byte, real byte follows in N+1
    store_to_uart = 1'b1;
    mmio_uart_data_in = 8'hFF;
    @(negedge clk);
    store_to_uart = 1'b0;
    mmio_uart_data_in = b;
    checks++;
    if (mmio_data_in_ready !== 1'b0) begin
      errors++;
      $display("FAIL tx_ready_drop: ready=%b expected 0", mmio_data_in_ready);
    end
    repeat (CPB) tx_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) repeat (CPB) tx_q.push_back(b[i]);
    repeat (CPB) tx_q.push_back(1'b1);
    // cycles N+2 .. N+101
    for (int k = 0; k < 10 * CPB; k++) begin
      @(negedge clk);
      mmio_uart_data_in = 8'hFF;
      store_to_uart = (k == 28);  // store while busy: must be dropped
      checks++;
      if (serial_out !== tx_q[0]) begin
        errors++;
        $display("FAIL tx_bit cycle N+%0d: serial_out=%b expected %b", k + 2, serial_out, tx_q[0]);
      end
      void'(tx_q.pop_front());
    end
    store_to_uart = 1'b0;
    checks++;
    if (mmio_data_in_ready !== 1'b0) begin
      errors++;
      $display("FAIL tx_ready_stop: ready=%b at N+101 expected 0", mmio_data_in_ready);
    end
    @(negedge clk);
    checks++;
    if (mmio_data_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL tx_ready_done: ready=%b at N+102 expected 1", mmio_data_in_ready);
    end
    quiet = 1'b1;
    repeat (3 * CPB) begin
      @(negedge clk);
      if (serial_out !== 1'b1) quiet = 1'b0;
    end
    checks++;
    if (quiet !== 1'b1) begin
      errors++;
      $display("FAIL tx_dropped_store: serial_out left idle after frame, expected 1");
    end
  endtask

  task automatic test_rx_single();
    send_frame(8'h3C, 1'b1);
    drain_rx("rx_single");
  endtask

  task automatic test_back_to_back();
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    drain_rx("rx_b2b");
  endtask

  task automatic test_rx_five();
    for (int i = 0; i < 5; i++) send_frame(8'h41 + 8'(i), 1'b1);
    drain_rx("rx_five");
    // load with nothing available must change nothing
    load_from_uart = 1'b1;
    @(negedge clk);
    load_from_uart = 1'b0;
    @(negedge clk);
    checks++;
    if (mmio_data_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rx_pop_empty: valid=%b expected 0", mmio_data_out_valid);
    end
  endtask

  task automatic test_rx_errors();
    serial_in = 1'b0;
    repeat (4) @(negedge clk);
    serial_in = 1'b1;
    repeat (15 * CPB) @(negedge clk);
    checks++;
    if (mmio_data_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rx_glitch: valid=%b expected 0", mmio_data_out_valid);
    end
    send_frame(8'h96, 1'b0);
    repeat (5 * CPB) @(negedge clk);
    checks++;
    if (mmio_data_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rx_framing: valid=%b expected 0", mmio_data_out_valid);
    end
    send_frame(8'h5A, 1'b1);
    drain_rx("rx_recover");
  endtask

  task automatic test_counters();
    logic pat [5];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    mmio_reset_cnt = 1'b1;
    inst_wb_nop_or_clear = 1'b1;
    @(negedge clk);
    mmio_reset_cnt = 1'b0;
    for (int i = 0; i < 5; i++) begin
      inst_wb_nop_or_clear = pat[i];
      @(negedge clk);
    end
    inst_wb_nop_or_clear = 1'b0;
    checks++;
    if (mmio_instr_cnt !== 32'd3 || mmio_cycle_cnt !== 32'd5) begin
      errors++;
      $display("FAIL cnt_nop_pattern: ins=%0d cyc=%0d expected 3 5", mmio_instr_cnt, mmio_cycle_cnt);
    end
    repeat (7) @(negedge clk);
    mmio_reset_cnt = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (mmio_cycle_cnt !== 32'd0 || mmio_instr_cnt !== 32'd0) begin
        errors++;
        $display("FAIL cnt_hold%0d: cyc=%0d ins=%0d expected 0 0", i, mmio_cycle_cnt, mmio_instr_cnt);
      end
    end
    mmio_reset_cnt = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (mmio_cycle_cnt !== 32'd3 || mmio_instr_cnt !== 32'd3) begin
      errors++;
      $display("FAIL cnt_resume: cyc=%0d ins=%0d expected 3 3", mmio_cycle_cnt, mmio_instr_cnt);
    end
  endtask

  task automatic test_wrap();
    force dut.mmio_cycle_cnt = 32'hFFFF_FFFF;
    force dut.mmio_instr_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.mmio_cycle_cnt;
    release dut.mmio_instr_cnt;
    @(negedge clk);
    checks++;
    if (mmio_cycle_cnt !== 32'd0 || mmio_instr_cnt !== 32'd0) begin
      errors++;
      $display("FAIL cnt_wrap: cyc=%h ins=%h expected 0 0", mmio_cycle_cnt, mmio_instr_cnt);
    end
    @(negedge clk);
    checks++;
    if (mmio_cycle_cnt !== 32'd1 || mmio_instr_cnt !== 32'd1) begin
      errors++;
      $display("FAIL cnt_after_wrap: cyc=%0d ins=%0d expected 1 1", mmio_cycle_cnt, mmio_instr_cnt);
    end
  endtask

  task automatic test_reset_mid_frame();
    store_to_uart = 1'b1;
    @(negedge clk);
    store_to_uart = 1'b0;
    mmio_uart_data_in = 8'h00;
    serial_in = 1'b0;
    repeat (16) @(negedge clk);
    checks++;
    if (serial_out !== 1'b0) begin
      errors++;
      $display("FAIL mid_frame_busy: serial_out=%b expected 0", serial_out);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (serial_out !== 1'b1 || mmio_data_in_ready !== 1'b1 || mmio_data_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_frame_reset: so=%b rdy=%b vld=%b expected 1 1 0",
               serial_out, mmio_data_in_ready, mmio_data_out_valid);
    end
    rst = 1'b0;
    serial_in = 1'b1;
    repeat (15 * CPB) @(negedge clk);
    checks++;
    if (mmio_data_out_valid !== 1'b0 || serial_out !== 1'b1) begin
      errors++;
      $display("FAIL mid_frame_no_partial: vld=%b so=%b expected 0 1", mmio_data_out_valid, serial_out);
    end
  endtask

  initial begin
    test_reset();
    test_tx();
    test_rx_single();
    test_back_to_back();
    test_rx_five();
    test_rx_errors();
    test_counters();
    test_wrap();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
